muldiv_seq: RTL and testbench
=============================

MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 Parameter XLEN, default 32, operand and result width; only 32 is supported.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 flush  input  1  synchronous abort of any in-flight operation.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  block can accept a request.
REQ-007 funct3  input  3  M-extension op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-008 op_a  input  XLEN  rs1 operand (multiplicand/dividend).
REQ-009 op_b  input  XLEN  rs2 operand (multiplier/divisor).
REQ-010 rd_in  input  5  destination register tag.
REQ-011 resp_valid  output  1  result present.
REQ-012 resp_ready  input  1  consumer takes the result.
REQ-013 result  output  XLEN  operation result.
REQ-014 rd_out  output  5  tag captured with the request.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 The FSM SHALL have four states: IDLE, CALC, FIX and DONE.
REQ-017 req_ready SHALL equal (state==IDLE); a request is accepted on an edge where req_valid && req_ready && !flush.
REQ-018 On accept: SHALL latch funct3 and rd_in; SHALL latch op_a/op_b magnitudes (two's-complement negation where the op treats the operand as signed and its bit 31 is 1); SHALL record result sign; SHALL load iteration counter = 31; state → CALC.
REQ-019 CALC SHALL perform one radix-2 step per cycle (multiply: shift-add into a 64-bit product; divide: restoring shift-subtract, 32-bit quotient and remainder), decrement the counter, and go → FIX after the step with counter==0 (exactly 32 CALC cycles).
REQ-020 FIX SHALL apply sign correction and select the result (MUL: product[31:0]; MULH/MULHSU/MULHU: product[63:32]; DIV/DIVU: quotient; REM/REMU: remainder; remainder sign follows the dividend), then → DONE.
REQ-021 Latency: resp_valid SHALL first be high in the 34th cycle after the accept edge (1 IDLE→CALC + 32 CALC + 1 FIX).
REQ-022 DONE: resp_valid=1; result and rd_out SHALL be stable until the edge with resp_ready=1, then → IDLE.
REQ-023 No new request SHALL be accepted in the cycle of the response handshake; the earliest next accept is the following edge.
REQ-024 Divide by zero: DIV/DIVU quotient SHALL be 0xFFFFFFFF; REM/REMU SHALL return op_a unchanged.
REQ-025 Signed overflow (DIV, op_a=0x80000000, op_b=0xFFFFFFFF): quotient SHALL be 0x80000000; REM SHALL be 0.
REQ-026 flush SHALL take priority over all other events: next state IDLE from any state, operation discarded, no response produced; a req_valid in the same cycle is not accepted.
REQ-027 In IDLE, result and rd_out SHALL hold their last values; resp_valid=0.

Reset
REQ-028 With rst_n=0 at an edge: state=IDLE, resp_valid=0, result=0, rd_out=0, counter=0, busy=0, req_ready=1 after the edge.
REQ-029 Reset mid-operation SHALL discard the operation with no response; reset takes priority over flush and requests.

Configuration
REQ-030 Macro MULDIV_EARLY_OUT_EN, when defined: divide-by-zero and signed-overflow requests SHALL skip CALC and FIX, going IDLE→DONE with the REQ-024/025 result, so resp_valid is high in the first cycle after accept.
REQ-031 When MULDIV_EARLY_OUT_EN is undefined: those cases SHALL take the full REQ-021 latency with identical results; all other ops are unaffected either way.

Verification
REQ-032 MUL op_a=7, op_b=0xFFFFFFFD, resp_ready=1 -> result 0xFFFFFFEB, resp_valid in cycle 34, rd_out=rd_in.
REQ-033 MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF.
REQ-034 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/0 -> 0xFFFFFFFF; REMU 100/0 -> 100; DIV 0x80000000/-1 -> 0x80000000 at 34 cycles (macro off) or 1 cycle (macro on).
REQ-035 Hold resp_ready=0 for 5 cycles in DONE -> result/rd_out stable, req_ready=0; the following request is accepted only on the edge after the handshake.
REQ-036 Assert flush in CALC cycle 10 with req_valid=1 -> no response, IDLE next cycle, the simultaneous request not accepted; a later request completes normally.
REQ-037 Drive rst_n=0 for 1 cycle during FIX -> all outputs at REQ-028 values, no stray resp_valid.

Source files
------------

// File: rtl/muldiv_seq.sv
// Sequential RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide, 32 iterations.
// Optional macro MULDIV_EARLY_OUT_EN: divide-by-zero and signed-overflow requests go IDLE->DONE directly.
module muldiv_seq #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   input  logic [4:0]      rd_in,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [XLEN-1:0] result,
   output logic [4:0]      rd_out,
   output logic            busy
);

   localparam int CW = $clog2(XLEN);
   localparam logic [2:0] F_MUL    = 3'b000;
   localparam logic [2:0] F_MULH   = 3'b001;
   localparam logic [2:0] F_MULHSU = 3'b010;
   localparam logic [2:0] F_MULHU  = 3'b011;
   localparam logic [2:0] F_DIV    = 3'b100;
   localparam logic [2:0] F_DIVU   = 3'b101;
   localparam logic [2:0] F_REM    = 3'b110;

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t          r_state;
   logic [2:0]      r_funct3;
   logic [4:0]      r_tag;
   logic [XLEN-1:0] r_opnd;     // multiplicand magnitude or divisor magnitude
   logic [XLEN-1:0] r_hi;       // product high half / partial remainder
   logic [XLEN-1:0] r_lo;       // multiplier bits / dividend shifting into quotient
   logic            r_neg;
   logic            r_dz;
   logic [CW-1:0]   r_cnt;
   logic            r_resp_valid;
   logic [XLEN-1:0] r_result;
   logic [4:0]      r_rd_out;

   // Operand conditioning at accept time
   logic            w_a_sgn, w_b_sgn, w_a_neg, w_b_neg;
   logic [XLEN-1:0] w_a_mag, w_b_mag;

   assign w_a_sgn = (funct3 == F_MULH) | (funct3 == F_MULHSU) | (funct3 == F_DIV) | (funct3 == F_REM);
   assign w_b_sgn = (funct3 == F_MULH) | (funct3 == F_DIV) | (funct3 == F_REM);
   assign w_a_neg = w_a_sgn & op_a[XLEN-1];
   assign w_b_neg = w_b_sgn & op_b[XLEN-1];
   assign w_a_mag = w_a_neg ? (~op_a + 1'b1) : op_a;
   assign w_b_mag = w_b_neg ? (~op_b + 1'b1) : op_b;

   // One iteration of each datapath
   logic [XLEN:0]   w_sum;
   logic [XLEN+1:0] w_trial;
   logic            w_sub_ok;

   assign w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
   assign w_trial  = {1'b0, r_hi, r_lo[XLEN-1]} - {2'b00, r_opnd};
   assign w_sub_ok = (w_trial[XLEN+1:XLEN] == 2'b00);

   // Sign correction and result selection
   logic [2*XLEN-1:0] w_prod, w_prod_s;
   logic [XLEN-1:0]   w_quo_s, w_rem_s, w_fix;

   assign w_prod   = {r_hi, r_lo};
   assign w_prod_s = r_neg ? (~w_prod + 1'b1) : w_prod;
   assign w_quo_s  = r_dz ? '1 : (r_neg ? (~r_lo + 1'b1) : r_lo);
   assign w_rem_s  = r_neg ? (~r_hi + 1'b1) : r_hi;

   always_comb begin
      w_fix = w_rem_s;
      case (r_funct3)
         F_MUL:                     w_fix = w_prod_s[XLEN-1:0];
         F_MULH, F_MULHSU, F_MULHU: w_fix = w_prod_s[2*XLEN-1:XLEN];
         F_DIV, F_DIVU:             w_fix = w_quo_s;
         default:                   w_fix = w_rem_s;
      endcase
   end

`ifdef MULDIV_EARLY_OUT_EN
   logic            w_dz, w_ovf, w_early;
   logic [XLEN-1:0] w_early_res;

   assign w_dz        = funct3[2] & (op_b == '0);
   assign w_ovf       = ((funct3 == F_DIV) | (funct3 == F_REM)) &
                        (op_a == {1'b1, {(XLEN-1){1'b0}}}) & (op_b == '1);
   assign w_early     = w_dz | w_ovf;
   assign w_early_res = funct3[1] ? (w_dz ? op_a : '0)
                                  : (w_dz ? '1 : {1'b1, {(XLEN-1){1'b0}}});
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_funct3     <= '0;
         r_tag        <= '0;
         r_opnd       <= '0;
         r_hi         <= '0;
         r_lo         <= '0;
         r_neg        <= 1'b0;
         r_dz         <= 1'b0;
         r_cnt        <= '0;
         r_resp_valid <= 1'b0;
         r_result     <= '0;
         r_rd_out     <= '0;
      end else if (flush) begin
         r_state      <= IDLE;
         r_resp_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (req_valid) begin
`ifdef MULDIV_EARLY_OUT_EN
                  if (w_early) begin
                     r_result     <= w_early_res;
                     r_rd_out     <= rd_in;
                     r_resp_valid <= 1'b1;
                     r_state      <= DONE;
                  end else
`endif
                  begin
                     r_funct3 <= funct3;
                     r_tag    <= rd_in;
                     r_opnd   <= funct3[2] ? w_b_mag : w_a_mag;
                     r_hi     <= '0;
                     r_lo     <= funct3[2] ? w_a_mag : w_b_mag;
                     r_neg    <= (funct3 == F_REM) ? w_a_neg : (w_a_neg ^ w_b_neg);
                     r_dz     <= funct3[2] & (op_b == '0);
                     r_cnt    <= CW'(XLEN - 1);
                     r_state  <= CALC;
                  end
               end
            end
            CALC: begin
               if (r_funct3[2]) begin
                  r_hi <= w_sub_ok ? w_trial[XLEN-1:0] : {r_hi[XLEN-2:0], r_lo[XLEN-1]};
                  r_lo <= {r_lo[XLEN-2:0], w_sub_ok};
               end else begin
                  r_hi <= w_sum[XLEN:1];
                  r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
               end
               r_cnt <= r_cnt - CW'(1);
               if (r_cnt == '0) r_state <= FIX;
            end
            FIX: begin
               r_result     <= w_fix;
               r_rd_out     <= r_tag;
               r_resp_valid <= 1'b1;
               r_state      <= DONE;
            end
            DONE: begin
               if (resp_ready) begin
                  r_resp_valid <= 1'b0;
                  r_state      <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign req_ready  = (r_state == IDLE);
   assign busy       = (r_state != IDLE);
   assign resp_valid = r_resp_valid;
   assign result     = r_result;
   assign rd_out     = r_rd_out;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq: arithmetic vectors, latency, backpressure, flush, reset.
// Build with MULDIV_EARLY_OUT_EN defined to expect the short special-case latency.
`timescale 1ns/1ps
module tb_muldiv_seq;

   logic        clk = 1'b0;
   logic        rst_n, flush, req_valid, req_ready, resp_valid, resp_ready, busy;
   logic [2:0]  funct3;
   logic [31:0] op_a, op_b, result;
   logic [4:0]  rd_in, rd_out;

   int n_checks = 0;
   int n_fail   = 0;

`ifdef MULDIV_EARLY_OUT_EN
   localparam int SPECIAL_LAT = 1;
`else
   localparam int SPECIAL_LAT = 34;
`endif

   always #5 clk = ~clk;

   muldiv_seq #(.XLEN(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .funct3     (funct3),
      .op_a       (op_a),
      .op_b       (op_b),
      .rd_in      (rd_in),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .result     (result),
      .rd_out     (rd_out),
      .busy       (busy)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Presents a request at a falling edge; returns at the falling edge of cycle 1 after accept.
   task automatic send(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
      funct3    = f;
      op_a      = a;
      op_b      = b;
      rd_in     = rd;
      req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic wait_resp(output int lat);
      lat = 1;
      while (!resp_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp, input int exp_lat);
      int lat;
      send(f, a, b, rd);
      wait_resp(lat);
      $display("op %-12s f=%0d a=%08h b=%08h -> result=%08h rd=%0d latency=%0d", tag, f, a, b, result, rd_out, lat);
      check($sformatf("%s latency", tag), 64'(lat), 64'(exp_lat));
      check($sformatf("%s result", tag), 64'(result), 64'(exp));
      check($sformatf("%s rd_out", tag), 64'(rd_out), 64'(rd));
      @(negedge clk);
      check($sformatf("%s back to idle", tag), {61'd0, resp_valid, busy, req_ready}, 64'b001);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int lat;
      int seen;
      rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
      funct3 = '0; op_a = '0; op_b = '0; rd_in = '0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset outputs", {result, 3'd0, rd_out, resp_valid, busy, req_ready},
            {32'd0, 3'd0, 5'd0, 1'b0, 1'b0, 1'b1});
      rst_n = 1'b1;
      @(negedge clk);

      // Multiply vectors
      run_op("MUL 7*-3",   3'b000, 32'd7,        32'hFFFFFFFD, 5'd3,  32'hFFFFFFEB, 34);
      run_op("MULHU -1*-1", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'hFFFFFFFE, 34);
      run_op("MULH -1*-1", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5,  32'h00000000, 34);
      run_op("MULHSU",     3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'hFFFFFFFF, 34);
      run_op("MULHU 2^33", 3'b011, 32'h80000000, 32'd4,        5'd7,  32'h00000002, 34);
      run_op("MULH -2^32", 3'b001, 32'h80000000, 32'd2,        5'd8,  32'hFFFFFFFF, 34);

      // Divide vectors, including divide-by-zero and overflow
      run_op("DIV -7/2",   3'b100, 32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFD, 34);
      run_op("REM -7/2",   3'b110, 32'hFFFFFFF9, 32'd2,        5'd11, 32'hFFFFFFFF, 34);
      run_op("DIVU big/3", 3'b101, 32'hFFFFFFFF, 32'd3,        5'd12, 32'h55555555, 34);
      run_op("REMU 100/7", 3'b111, 32'd100,      32'd7,        5'd13, 32'd2,        34);
      run_op("DIVU 100/0", 3'b101, 32'd100,      32'd0,        5'd14, 32'hFFFFFFFF, SPECIAL_LAT);
      run_op("REMU 100/0", 3'b111, 32'd100,      32'd0,        5'd15, 32'd100,      SPECIAL_LAT);
      run_op("DIV -7/0",   3'b100, 32'hFFFFFFF9, 32'd0,        5'd16, 32'hFFFFFFFF, SPECIAL_LAT);
      run_op("REM -7/0",   3'b110, 32'hFFFFFFF9, 32'd0,        5'd17, 32'hFFFFFFF9, SPECIAL_LAT);
      run_op("DIV ovf",    3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd18, 32'h80000000, SPECIAL_LAT);
      run_op("REM ovf",    3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd19, 32'h00000000, SPECIAL_LAT);

      // Backpressure: hold the response, offer a new request meanwhile
      resp_ready = 1'b0;
      send(3'b100, 32'hFFFFFFF9, 32'd2, 5'd9);
      wait_resp(lat);
      $display("op %-12s held response result=%08h rd=%0d latency=%0d", "DIV hold", result, rd_out, lat);
      check("hold latency", 64'(lat), 64'd34);
      funct3 = 3'b111; op_a = 32'd100; op_b = 32'd7; rd_in = 5'd21; req_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check($sformatf("hold %0d state", i), {result, 3'd0, rd_out, resp_valid, req_ready},
               {32'hFFFFFFFD, 3'd0, 5'd9, 1'b1, 1'b0});
      end
      resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("after handshake", {61'd0, resp_valid, busy, req_ready}, 64'b001);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      wait_resp(lat);
      $display("op %-12s queued request result=%08h rd=%0d latency=%0d", "REMU next", result, rd_out, lat);
      check("next latency", 64'(lat), 64'd34);
      check("next result", 64'(result), 64'd2);
      check("next rd_out", 64'(rd_out), 64'd21);
      @(negedge clk);

      // Flush in CALC cycle 10 together with a new request
      send(3'b000, 32'd5, 32'd6, 5'd22);
      repeat (9) @(negedge clk);
      flush = 1'b1;
      funct3 = 3'b000; op_a = 32'd3; op_b = 32'd3; rd_in = 5'd23; req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      flush = 1'b0; req_valid = 1'b0;
      check("after flush", {61'd0, resp_valid, busy, req_ready}, 64'b001);
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (resp_valid || busy) seen++;
      end
      $display("op %-12s flushed, stray activity cycles=%0d", "MUL flush", seen);
      check("flush no response", 64'(seen), 64'd0);
      run_op("MUL 5*6",    3'b000, 32'd5,        32'd6,        5'd24, 32'd30,       34);

      // Reset asserted for one edge while in FIX
      send(3'b101, 32'd1000, 32'd10, 5'd25);
      repeat (32) @(negedge clk);
      check("in FIX", {62'd0, resp_valid, busy}, 64'b01);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check("reset in FIX", {result, 3'd0, rd_out, resp_valid, busy, req_ready},
            {32'd0, 3'd0, 5'd0, 1'b0, 1'b0, 1'b1});
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (resp_valid) seen++;
      end
      $display("op %-12s reset during FIX, stray responses=%0d", "DIVU reset", seen);
      check("reset no response", 64'(seen), 64'd0);
      run_op("DIVU 1000/10", 3'b101, 32'd1000,   32'd10,       5'd26, 32'd100,      34);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
